// File: rtl/rv_pipeline_pkg.sv
// Shared definitions for the RV32 5-stage pipeline front end:
// bubble instruction, default reset vector, fetch FSM state encoding
// and a word-alignment helper.
package rv_pipeline_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;  // ADDI x0,x0,0
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Instruction fetches are word-aligned; low two address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read handshake between the IF stage (master)
// and the instruction memory / cache (slave).
interface if_fetch_unit_if;

  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;

  modport master (
    output IMEM_READ,
    output IMEM_ADDRESS,
    input  IMEM_READDATA,
    input  IMEM_BUSYWAIT
  );

  modport slave (
    input  IMEM_READ,
    input  IMEM_ADDRESS,
    output IMEM_READDATA,
    output IMEM_BUSYWAIT
  );

endinterface

// File: rtl/if_fetch_unit_pc_register.sv
// Program counter register: asynchronous reset to RESET_VECTOR,
// loads the next PC only when load_en_i is asserted.
module pc_register #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_en_i,
  input  logic [31:0] pc_d_i,
  output logic [31:0] pc_q_o
);

  logic [31:0] pc_q;

  // PC storage; holds its value unless a new PC is loaded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_VECTOR;
    end else if (load_en_i) begin
      pc_q <= pc_d_i;
    end else begin
      pc_q <= pc_q;
    end
  end

  assign pc_q_o = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage of the RV32 5-stage pipeline. Owns the PC, drives the
// instruction-memory read handshake, applies EX redirects and hazard
// stalls, and presents the fetched word to the IF/ID register.
// A redirect that arrives during a memory miss is parked in a latch
// while the in-flight read drains (DRAIN state), so a request is
// never abandoned mid-transaction.
// Optional feature: define IF_PERF_COUNTERS_EN to add FETCH_COUNT and
// STALL_COUNT saturating performance counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = rv_pipeline_pkg::DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = rv_pipeline_pkg::NOP_INSTR
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   PC_SEL,
  input  logic [31:0]            BRANCH_TARGET,
  input  logic                   HAZARD_STALL,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            INSTRUCTION,
  output logic [31:0]            PC_PLUS_4,
  output logic [31:0]            PC_DIRECT,
  output logic                   BUSYWAIT
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0]            FETCH_COUNT,
  output logic [31:0]            STALL_COUNT
`endif
);

  import rv_pipeline_pkg::*;

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  target_q;
  logic [31:0]  target_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         pc_load_s;
  logic         mem_busy_s;
  logic         fetch_done_s;

  assign mem_busy_s = imem.IMEM_BUSYWAIT;

  pc_register #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_register (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .load_en_i (pc_load_s),
    .pc_d_i    (pc_d),
    .pc_q_o    (pc_q)
  );

  // Next-state, redirect latch and next-PC selection with miss/redirect/stall priority.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    pc_d      = pc_q;
    pc_load_s = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (mem_busy_s && PC_SEL) begin
          // Redirect during a miss: park it until the read completes.
          target_d = align_word(BRANCH_TARGET);
          state_d  = DRAIN;
        end else if (mem_busy_s) begin
          pc_load_s = 1'b0;
        end else if (PC_SEL) begin
          // Redirect outranks a hazard stall; the stalled op is flushed downstream.
          pc_d      = align_word(BRANCH_TARGET);
          pc_load_s = 1'b1;
        end else if (HAZARD_STALL) begin
          pc_load_s = 1'b0;
        end else begin
          pc_d      = pc_q + 32'd4;
          pc_load_s = 1'b1;
        end
      end
      DRAIN: begin
        // EX is frozen while draining, so any PC_SEL here is the same redirect.
        if (!mem_busy_s) begin
          pc_d      = target_q;
          pc_load_s = 1'b1;
          state_d   = FETCH;
        end else begin
          pc_load_s = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Fetch FSM state and parked redirect target.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= BOOT;
      target_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Outputs follow state, PC and memory inputs directly so IF/ID sees them this cycle.
  always_comb begin
    imem.IMEM_READ    = (state_q == FETCH) || (state_q == DRAIN);
    imem.IMEM_ADDRESS = pc_q;
    BUSYWAIT          = imem.IMEM_READ & mem_busy_s;
    fetch_done_s      = (state_q == FETCH) && !mem_busy_s;
    if (fetch_done_s) begin
      INSTRUCTION = imem.IMEM_READDATA;
    end else begin
      INSTRUCTION = NOP_INSTR;
    end
    PC_DIRECT = pc_q;
    PC_PLUS_4 = pc_q + 32'd4;
  end

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Saturating counters of completed fetches and pipeline stall cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      if (fetch_done_s && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end else begin
        fetch_cnt_q <= fetch_cnt_q;
      end
      if (BUSYWAIT && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign FETCH_COUNT = fetch_cnt_q;
  assign STALL_COUNT = stall_cnt_q;
`endif

endmodule
